// File: rtl/axi_stream_burst_writer_if.sv
// rtl/axi_stream_burst_writer_if.sv - AXI4 write-only channel bundle (AW/W/B) between burst writer and DDR3 port.
interface axi_stream_burst_writer_if;
    logic [31:0] awaddr;
    logic [7:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awqos;
    logic        awurgent;
    logic        awpoison;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awlock, awqos, awurgent, awpoison, awvalid,
        input  awready,
        output wdata, wstrb, wvalid, wlast,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awlock, awqos, awurgent, awpoison, awvalid,
        output awready,
        input  wdata, wstrb, wvalid, wlast,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_stream_burst_writer.sv
// rtl/axi_stream_burst_writer.sv - stream-to-DDR3 INCR burst writer with FWFT buffer FIFO.
// Optional AXI_BRESP_CHECK_EN: sticky err_flag on non-OKAY write responses.
module axi_stream_burst_writer #(
    parameter int         CTRL_ADDR_WIDTH = 27,
    parameter int         BURST_LEN       = 16,
    parameter int         FIFO_DEPTH      = 64,
    parameter logic [7:0] AXI_ID          = 8'd0
) (
    input  logic                       axi_clk,
    input  logic                       top_rst_n,
    input  logic                       ddr_init_done,
    input  logic                       cfg_start,
    input  logic [CTRL_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [23:0]                cfg_total_beats,
    input  logic [63:0]                s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err_flag,
    axi_stream_burst_writer_if.master  axi
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_DATA, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CTRL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [23:0]                total_q, total_d;
    logic [23:0]                remaining_q, remaining_d;
    logic [23:0]                accepted_q, accepted_d;
    logic [7:0]                 beat_q, beat_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                count_q, count_d;
    logic [63:0]                mem_q [FIFO_DEPTH];

    logic [23:0] beats;
    logic        start_ok, push, pop, b_hs, fifo_full;

    assign beats     = (remaining_q > 24'(BURST_LEN)) ? 24'(BURST_LEN) : remaining_q;
    assign start_ok  = cfg_start && ddr_init_done && (state_q == S_IDLE);
    assign fifo_full = (count_q == (PW+1)'(FIFO_DEPTH));
    assign s_ready   = busy && !fifo_full && (accepted_q < total_q);
    assign push      = s_valid && s_ready;
    assign pop       = axi.wvalid && axi.wready;
    assign b_hs      = axi.bvalid && axi.bready;

    always_ff @(posedge axi_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_ok) state_d = (cfg_total_beats == 24'd0) ? S_DONE : S_WAIT_DATA;
            // Bursts only start once every beat is buffered, so W never starves mid-burst.
            S_WAIT_DATA: if (24'(count_q) >= beats) state_d = S_AW;
            S_AW:        if (axi.awready) state_d = S_W;
            S_W:         if (pop && axi.wlast) state_d = S_B;
            S_B:         if (axi.bvalid) state_d = (remaining_q == beats) ? S_DONE : S_WAIT_DATA;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_WAIT_DATA) || (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
        done        = (state_q == S_DONE);
        axi.awvalid = (state_q == S_AW);
        axi.wvalid  = (state_q == S_W);
        axi.wlast   = (state_q == S_W) && (beat_q == 8'(beats - 24'd1));
        axi.bready  = (state_q == S_B);
        axi.awlen   = (state_q == S_AW) ? 8'(beats - 24'd1) : 8'd0;
    end

    assign axi.awaddr   = 32'(addr_q);
    assign axi.awid     = AXI_ID;
    assign axi.awsize   = 3'd3;
    assign axi.awburst  = 2'b01;
    assign axi.awlock   = 1'b0;
    assign axi.awqos    = 4'd0;
    assign axi.awurgent = 1'b0;
    assign axi.awpoison = 1'b0;
    assign axi.wstrb    = 8'hFF;
    assign axi.wdata    = mem_q[rd_ptr_q];

    always_comb begin
        addr_d      = addr_q;
        total_d     = total_q;
        remaining_d = remaining_q;
        accepted_d  = accepted_q;
        beat_d      = beat_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (start_ok) begin
            addr_d      = cfg_base_addr;
            total_d     = cfg_total_beats;
            remaining_d = cfg_total_beats;
            accepted_d  = 24'd0;
        end
        if (push) begin
            accepted_d = accepted_q + 24'd1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            beat_d   = beat_q + 8'd1;
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        if (axi.awvalid && axi.awready) beat_d = 8'd0;
        if (b_hs) begin
            addr_d      = addr_q + CTRL_ADDR_WIDTH'({beats, 3'b000});
            remaining_d = remaining_q - beats;
        end
    end

    always_ff @(posedge axi_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            addr_q      <= '0;
            total_q     <= '0;
            remaining_q <= '0;
            accepted_q  <= '0;
            beat_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            addr_q      <= addr_d;
            total_q     <= total_d;
            remaining_q <= remaining_d;
            accepted_q  <= accepted_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

`ifdef AXI_BRESP_CHECK_EN
    logic        err_flag_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge axi_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= 16'd0;
        end else if (start_ok) begin
            err_flag_q <= 1'b0;
        end else if (b_hs && (axi.bresp != 2'b00)) begin
            err_flag_q <= 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_flag = err_flag_q;
`else
    assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// tb/tb_axi_stream_burst_writer.sv - directed bench for axi_stream_burst_writer with DDR3 write-slave model.
module tb_axi_stream_burst_writer;
    logic        axi_clk = 1'b0;
    logic        top_rst_n, ddr_init_done, cfg_start;
    logic [26:0] cfg_base_addr;
    logic [23:0] cfg_total_beats;
    logic [63:0] s_data;
    logic        s_valid, s_ready, busy, done, err_flag;

    axi_stream_burst_writer_if axi ();

    axi_stream_burst_writer dut (
        .axi_clk(axi_clk), .top_rst_n(top_rst_n), .ddr_init_done(ddr_init_done), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_total_beats(cfg_total_beats), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done), .err_flag(err_flag), .axi(axi)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model controls, written by the stimulus process only.
    bit          stall_en   = 1'b0;
    int          duty       = 100;
    int          src_limit  = 0;
    logic [1:0]  resp_first = 2'b00;
    logic [15:0] tag        = 16'h0;
    int          clr_gen    = 0;

    // Model logs, written by the model process only.
    logic [31:0] aw_addr_l[$];
    logic [7:0]  aw_len_l[$];
    logic [63:0] w_data_l[$];
    int          wlast_pos_l[$];
    int          src_idx, done_cnt, b_cnt, b_at_done, awv_seen, stab_err, beat_in_burst, seen_gen;
    bit          b_pending, b_hs, aw_hold, w_hold, wl_h;
    logic [31:0] aw_addr_h;
    logic [7:0]  aw_len_h;
    logic [63:0] wd_h;

    initial begin : ddr_model
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 8'd0;
        s_valid = 0; s_data = 0;
        seen_gen = 0; src_idx = 0; done_cnt = 0; b_cnt = 0; b_at_done = 0; awv_seen = 0; stab_err = 0;
        beat_in_burst = 0; b_pending = 0; aw_hold = 0; w_hold = 0;
        forever begin
            @(posedge axi_clk);
            b_hs = 0;
            if (clr_gen != seen_gen) begin
                aw_addr_l.delete(); aw_len_l.delete(); w_data_l.delete(); wlast_pos_l.delete();
                src_idx = 0; done_cnt = 0; b_cnt = 0; b_at_done = 0; awv_seen = 0; stab_err = 0;
                seen_gen = clr_gen;
            end
            if (!top_rst_n) begin
                b_pending = 0; aw_hold = 0; w_hold = 0; beat_in_burst = 0;
            end else begin
                if (aw_hold && (!axi.awvalid || axi.awaddr !== aw_addr_h || axi.awlen !== aw_len_h)) stab_err++;
                if (w_hold && (!axi.wvalid || axi.wdata !== wd_h || axi.wlast !== wl_h)) stab_err++;
                aw_hold = axi.awvalid && !axi.awready;
                aw_addr_h = axi.awaddr; aw_len_h = axi.awlen;
                w_hold = axi.wvalid && !axi.wready;
                wd_h = axi.wdata; wl_h = axi.wlast;
                if (axi.awvalid) awv_seen++;
                if (axi.awvalid && axi.awready) begin
                    aw_addr_l.push_back(axi.awaddr);
                    aw_len_l.push_back(axi.awlen);
                end
                if (axi.wvalid && axi.wready) begin
                    w_data_l.push_back(axi.wdata);
                    beat_in_burst++;
                    if (axi.wlast) begin
                        wlast_pos_l.push_back(beat_in_burst);
                        beat_in_burst = 0;
                        b_pending = 1;
                    end
                end
                if (axi.bvalid && axi.bready) begin
                    b_cnt++; b_pending = 0; b_hs = 1;
                end
                if (s_valid && s_ready) src_idx++;
                if (done) begin
                    done_cnt++; b_at_done = b_cnt;
                end
            end
            @(negedge axi_clk);
            axi.awready = !stall_en || ($urandom_range(0, 99) < 40);
            axi.wready  = !stall_en || ($urandom_range(0, 99) < 50);
            if (b_hs || !top_rst_n) axi.bvalid = 0;
            else if (!axi.bvalid && b_pending && (!stall_en || $urandom_range(0, 1) == 1)) begin
                axi.bvalid = 1;
                axi.bresp  = (b_cnt == 0) ? resp_first : 2'b00;
            end
            s_valid = top_rst_n && (src_idx < src_limit) && ($urandom_range(0, 99) < duty);
            s_data  = {tag, 16'h0, 32'(src_idx)};
        end
    end

    task automatic start_xfer(input logic [26:0] base, input int total, input int limit,
                              input logic [15:0] t, input int dty, input bit stl, input logic [1:0] rf);
        src_limit = limit; tag = t; duty = dty; stall_en = stl; resp_first = rf;
        clr_gen++;
        @(posedge axi_clk);
        @(negedge axi_clk);
        cfg_base_addr = base; cfg_total_beats = 24'(total); cfg_start = 1;
        @(negedge axi_clk);
        cfg_start = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge axi_clk);
        check({name, "_timeout"}, 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge axi_clk);
    endtask

    function automatic int data_mism(input logic [15:0] t);
        int m = 0;
        foreach (w_data_l[i]) if (w_data_l[i] !== {t, 16'h0, 32'(i)}) m++;
        return m;
    endfunction

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_ctrl"}, 64'({s_ready, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, err_flag}), 64'd0);
        check({name, "_awaddr"}, 64'(axi.awaddr), 64'd0);
        check({name, "_awlen"}, 64'(axi.awlen), 64'd0);
    endtask

`ifdef AXI_BRESP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    initial begin
        top_rst_n = 0; ddr_init_done = 1; cfg_start = 0; cfg_base_addr = '0; cfg_total_beats = '0;
        repeat (3) @(negedge axi_clk);
        check_idle_outputs("rst");
        top_rst_n = 1;
        @(negedge axi_clk);

        // 48 beats in three full bursts
        start_xfer(27'h1000, 48, 48, 16'h0001, 100, 0, 2'b00);
        wait_done("t1");
        check("t1_aw_cnt", 64'(aw_addr_l.size()), 64'd3);
        if (aw_addr_l.size() == 3) begin
            check("t1_addr0", 64'(aw_addr_l[0]), 64'h1000);
            check("t1_addr1", 64'(aw_addr_l[1]), 64'h1080);
            check("t1_addr2", 64'(aw_addr_l[2]), 64'h1100);
            check("t1_lens", 64'({aw_len_l[0], aw_len_l[1], aw_len_l[2]}), 64'h0F0F0F);
        end
        check("t1_beats", 64'(w_data_l.size()), 64'd48);
        check("t1_data", 64'(data_mism(16'h0001)), 64'd0);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_b_at_done", 64'(b_at_done), 64'd3);
        check("t1_busy_end", 64'(busy), 64'd0);

        // 20 beats, source offers 30: full burst then short burst
        start_xfer(27'h2000, 20, 30, 16'h0002, 100, 0, 2'b00);
        wait_done("t2");
        check("t2_aw_cnt", 64'(aw_addr_l.size()), 64'd2);
        if (aw_addr_l.size() == 2) begin
            check("t2_addr1", 64'(aw_addr_l[1]), 64'h2080);
            check("t2_lens", 64'({aw_len_l[0], aw_len_l[1]}), 64'h0F03);
        end
        check("t2_wlast_cnt", 64'(wlast_pos_l.size()), 64'd2);
        if (wlast_pos_l.size() == 2) check("t2_wlast_pos", 64'({16'(wlast_pos_l[0]), 16'(wlast_pos_l[1])}), 64'h0010_0004);
        check("t2_accepted", 64'(src_idx), 64'd20);
        check("t2_data", 64'(data_mism(16'h0002)), 64'd0);

        // random backpressure on all channels, sparse source
        start_xfer(27'h3000, 40, 40, 16'h0003, 30, 1, 2'b00);
        wait_done("t3");
        check("t3_aw_cnt", 64'(aw_addr_l.size()), 64'd3);
        if (aw_len_l.size() == 3) check("t3_lens", 64'({aw_len_l[0], aw_len_l[1], aw_len_l[2]}), 64'h0F0F07);
        check("t3_stable", 64'(stab_err), 64'd0);
        check("t3_beats", 64'(w_data_l.size()), 64'd40);
        check("t3_data", 64'(data_mism(16'h0003)), 64'd0);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);

        // zero-length job, then start while DDR not ready
        start_xfer(27'h0, 0, 0, 16'h0004, 100, 0, 2'b00);
        check("t4_done_early", 64'(done), 64'd1);
        repeat (10) @(negedge axi_clk);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);
        check("t4_no_aw", 64'(awv_seen), 64'd0);
        ddr_init_done = 0;
        start_xfer(27'h0, 5, 5, 16'h0005, 100, 0, 2'b00);
        repeat (10) @(negedge axi_clk);
        check("t4_ign_busy", 64'(busy), 64'd0);
        check("t4_ign_done", 64'(done_cnt), 64'd0);
        check("t4_ign_aw", 64'(awv_seen), 64'd0);
        ddr_init_done = 1;

        // reset during W of burst 2, then a clean job
        start_xfer(27'h4000, 48, 48, 16'h0006, 100, 0, 2'b00);
        for (int i = 0; i < 2000 && w_data_l.size() < 20; i++) @(negedge axi_clk);
        check("t5_reach_w2", 64'(w_data_l.size() >= 20 && axi.wvalid), 64'd1);
        top_rst_n = 0;
        @(posedge axi_clk);
        #1;
        check_idle_outputs("t5_rst");
        @(negedge axi_clk);
        top_rst_n = 1;
        start_xfer(27'h5000, 16, 16, 16'h0007, 100, 0, 2'b00);
        wait_done("t5");
        check("t5_aw_cnt", 64'(aw_addr_l.size()), 64'd1);
        if (aw_addr_l.size() == 1) check("t5_addr", 64'(aw_addr_l[0]), 64'h5000);
        check("t5_data", 64'(data_mism(16'h0007)), 64'd0);
        check("t5_beats", 64'(w_data_l.size()), 64'd16);

        // SLVERR on the first burst
        start_xfer(27'h6000, 32, 32, 16'h0008, 100, 0, 2'b10);
        wait_done("t6");
        check("t6_err_set", 64'(err_flag), 64'(ERR_EXP));
        repeat (5) @(negedge axi_clk);
        check("t6_err_sticky", 64'(err_flag), 64'(ERR_EXP));
        start_xfer(27'h0, 0, 0, 16'h0009, 100, 0, 2'b00);
        check("t6_err_clr", 64'(err_flag), 64'd0);
        wait_done("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
